raster_pixel_counter: RTL and testbench
=======================================

Name: raster_pixel_counter

Overview:
- Parametrised successor to the single-width pixel iteration counter.
- Walks a pixel grid of H_RES x V_RES in raster order, top-left to bottom-right, one pixel per valid/ready handshake.
- Supplies column, row and linear address to the downstream Mandelbrot iteration engine and colour-map stage.
- Supports single-frame and continuous modes, abort, and frame-completion signalling.

Parameters:
- H_RES, 160, pixels per row (>=2)
- V_RES, 120, rows per frame (>=2)
- X_W, $clog2(H_RES), column output width
- Y_W, $clog2(V_RES), row output width
- ADDR_W, $clog2(H_RES*V_RES), linear address width
- CONTINUOUS, 0, 1 = wrap to next frame automatically; 0 = stop after one frame

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  synchronous cancel of the scan in progress
- ready  in  1  downstream accepts the current pixel
- valid  out  1  x/y/addr hold a pixel to be consumed
- x  out  X_W  current column
- y  out  Y_W  current row
- addr  out  ADDR_W  y*H_RES+x
- busy  out  1  high in SCAN state
- frame_done  out  1  one-cycle pulse after the final pixel of a frame transfers

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, x=0, y=0, addr=0, valid=0, busy=0, frame_done=0.
- States: IDLE, SCAN.
- IDLE to SCAN: on start=1 and abort=0. The next cycle has valid=1, busy=1, x=0, y=0, addr=0.
- Transfer: valid && ready in SCAN.
  - Without a transfer, x/y/addr hold stable while valid stays high.
  - valid never drops in SCAN except on abort or frame end.
- Advance on transfer:
  - x<H_RES-1: x+1, y unchanged.
  - x==H_RES-1: x=0, y+1.
  - addr increments by 1 on every transfer. It is built incrementally, with no multiplier.
- Last pixel (x==H_RES-1, y==V_RES-1) transfers:
  - frame_done=1 for exactly the next cycle.
  - CONTINUOUS=0: go to IDLE next cycle with valid=0, busy=0, x=y=addr=0.
  - CONTINUOUS=1: stay in SCAN with x=y=addr=0 and valid=1. There are no bubble cycles between frames.
- abort=1 in SCAN:
  - Next cycle: IDLE, valid=0, busy=0, x=y=addr=0, no frame_done.
  - abort has priority over a simultaneous transfer, including on the last pixel. The downstream still owns the pixel it accepted that cycle.
- start while in SCAN: ignored.
- start and abort together in IDLE: stay IDLE.
- abort in IDLE: no effect.
- Latency: start to first valid is 1 cycle. Each transfer to the next pixel is 0 extra cycles, so full throughput is one pixel per clock when ready is held high.
- Widths: x, y and addr never exceed H_RES-1, V_RES-1 and H_RES*V_RES-1 respectively. Comparisons use full-width constants.

Optional Feature:
- Macro: RASTER_FRAME_CNT_EN.
- Defined:
  - Adds output frame_count [15:0].
  - Increments on every frame_done pulse and saturates at 16'hFFFF.
  - Reset value 0; not cleared by abort or start.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package raster_pkg:
  - Scan state enum (IDLE, SCAN).
  - Default resolution constants H_RES_DEF=160 and V_RES_DEF=120, shared with the iteration engine and frame buffer.
- Sub-module wrap_counter #(MAX, W):
  - Ports: inc, clr, count, at_max.
  - Counts 0..MAX-1 and wraps.
  - Instantiated twice, once for columns and once for rows (row inc = column at_max && inc).
  - addr stays in the top level.

Test Plan:
- H_RES=4, V_RES=3, CONTINUOUS=0, ready=1, pulse start:
  - valid rises 1 cycle later.
  - 12 transfers give (x,y,addr) = (0,0,0) ... (3,0,3), (0,1,4) ... (3,2,11).
  - frame_done pulses once; then valid=0, busy=0.
- Same config with ready toggling 1,0,0,1 repeatedly: outputs hold across ready=0 cycles, no pixel is skipped or repeated, and the addr sequence is still 0..11.
- CONTINUOUS=1, ready=1, 30 cycles: after addr=11 the next valid pixel is (0,0,0) with no gap, and frame_done pulses every 12 transfers.
- abort asserted at (2,1,6) with ready=1: next cycle valid=0, busy=0, x=y=addr=0, frame_done stays 0; a subsequent start restarts from addr=0.
- Reset edge cases:
  - Assert rst low mid-frame between clock edges: outputs clear immediately to reset values.
  - start pulsed during SCAN: ignored, with the sequence uninterrupted.
- With RASTER_FRAME_CNT_EN defined and CONTINUOUS=1: frame_count reads 3 after three frame_done pulses and is unchanged by a subsequent abort.

Source files
------------

// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared scan state and default resolution for the raster pixel pipeline
package raster_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-MAX counter with clear priority and terminal-count flag
module wrap_counter #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/raster_pixel_counter.sv
// rtl/raster_pixel_counter.sv - raster-order pixel walker with valid/ready output
// Optional frame counter output enabled by RASTER_FRAME_CNT_EN.
module raster_pixel_counter
  import raster_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int X_W        = $clog2(H_RES),
  parameter int Y_W        = $clog2(V_RES),
  parameter int ADDR_W     = $clog2(H_RES * V_RES),
  parameter int CONTINUOUS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ready,
  output logic              valid,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              frame_done
`ifdef RASTER_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_count
`endif
);

  scan_state_t state;
  logic        xfer;
  logic        x_at_max;
  logic        y_at_max;
  logic        clr;
  logic        last_xfer;

  assign xfer      = (state == SCAN) && valid && ready;
  // abort beats a same-cycle transfer, so the counters clear rather than advance
  assign clr       = (state == SCAN) && abort;
  assign last_xfer = xfer && !abort && x_at_max && y_at_max;

  wrap_counter #(.MAX(H_RES), .W(X_W)) u_col (
    .clk    (clk),
    .rst    (rst),
    .inc    (xfer),
    .clr    (clr),
    .count  (x),
    .at_max (x_at_max)
  );

  wrap_counter #(.MAX(V_RES), .W(Y_W)) u_row (
    .clk    (clk),
    .rst    (rst),
    .inc    (xfer && x_at_max),
    .clr    (clr),
    .count  (y),
    .at_max (y_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      addr       <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= SCAN;
            valid <= 1'b1;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (abort) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            addr  <= '0;
          end else if (last_xfer) begin
            addr       <= '0;
            frame_done <= 1'b1;
            if (CONTINUOUS == 0) begin
              state <= IDLE;
              valid <= 1'b0;
              busy  <= 1'b0;
            end
          end else if (xfer) begin
            addr <= addr + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RASTER_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_count <= '0;
    end else if (last_xfer && frame_count != 16'hFFFF) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_raster_pixel_counter.sv
// tb/tb_raster_pixel_counter.sv - directed checks of raster_pixel_counter on a 4x3 grid
module tb_raster_pixel_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, ready;
  logic       valid, busy, frame_done;
  logic [1:0] x, y;
  logic [3:0] addr;
  logic       start_c, abort_c, ready_c;
  logic       valid_c, busy_c, frame_done_c;
  logic [1:0] x_c, y_c;
  logic [3:0] addr_c;
`ifdef RASTER_FRAME_CNT_EN
  logic [15:0] frame_count, frame_count_c;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int idx, k, j, pulses;

  always #5 clk = ~clk;

  raster_pixel_counter #(.H_RES(4), .V_RES(3), .CONTINUOUS(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .ready      (ready),
    .valid      (valid),
    .x          (x),
    .y          (y),
    .addr       (addr),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef RASTER_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  raster_pixel_counter #(.H_RES(4), .V_RES(3), .CONTINUOUS(1)) dut_c (
    .clk        (clk),
    .rst        (rst),
    .start      (start_c),
    .abort      (abort_c),
    .ready      (ready_c),
    .valid      (valid_c),
    .x          (x_c),
    .y          (y_c),
    .addr       (addr_c),
    .busy       (busy_c),
    .frame_done (frame_done_c)
`ifdef RASTER_FRAME_CNT_EN
    ,
    .frame_count(frame_count_c)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pix(input string tag, input int a);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_x"}, 32'(x), 32'(a % 4));
    check({tag, "_y"}, 32'(y), 32'(a / 4));
    check({tag, "_addr"}, 32'(addr), 32'(a));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    start_c = 1'b0; abort_c = 1'b0; ready_c = 1'b0;
    #2;
    check_idle("reset");
    check("reset_fd", 32'(frame_done), 32'd0);
    check("reset_c_valid", 32'(valid_c), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    check_idle("idle");

    // start together with abort, and abort alone, leave the scanner idle
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check_idle("start_abort");
    abort = 1'b1; tick(); abort = 1'b0;
    check_idle("abort_idle");

    // single frame with ready held high; start during SCAN is ignored
    ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    check("first_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 12; i++) begin
      check_pix("frame", i);
      check("frame_fd", 32'(frame_done), 32'd0);
      if (i == 5) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("end_fd", 32'(frame_done), 32'd1);
    check_idle("end");
    tick();
    check("end_fd_clear", 32'(frame_done), 32'd0);
    check("end_valid_stay", 32'(valid), 32'd0);

    // ready toggling 1,0,0,1: pixels hold while stalled
    ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    idx = 0; k = 0;
    while (idx < 12 && k < 200) begin
      ready = (k % 4 == 0) || (k % 4 == 3);
      check_pix("toggle", idx);
      tick();
      if (ready) idx++;
      k++;
    end
    check("toggle_count", 32'(idx), 32'd12);
    check("toggle_cycles", 32'(k), 32'd24);
    check("toggle_fd", 32'(frame_done), 32'd1);
    check_idle("toggle_end");
    ready = 1'b0;

    // abort at (2,1,6) wins over the simultaneous transfer
    ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    check_pix("pre_abort", 6);
    abort = 1'b1; tick(); abort = 1'b0;
    check_idle("abort");
    check("abort_fd", 32'(frame_done), 32'd0);
    tick();
    check("abort_fd_late", 32'(frame_done), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check_pix("restart", 0);

    // asynchronous reset between clock edges
    tick(); tick();
    check_pix("pre_rst", 2);
    #3; rst = 1'b0; #1;
    check_idle("async_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    check_idle("post_rst");

    // continuous mode: back-to-back frames with no bubble
    ready_c = 1'b1; start_c = 1'b1; tick(); start_c = 1'b0;
    pulses = 0;
    for (int i = 0; i < 37; i++) begin
      j = i % 12;
      check("cont_valid", 32'(valid_c), 32'd1);
      check("cont_busy", 32'(busy_c), 32'd1);
      check("cont_x", 32'(x_c), 32'(j % 4));
      check("cont_y", 32'(y_c), 32'(j / 4));
      check("cont_addr", 32'(addr_c), 32'(j));
      check("cont_fd", 32'(frame_done_c), 32'((i > 0) && (j == 0)));
      if (frame_done_c) pulses++;
      tick();
    end
    check("cont_pulses", 32'(pulses), 32'd3);
`ifdef RASTER_FRAME_CNT_EN
    check("frame_count", 32'(frame_count_c), 32'd3);
`endif
    abort_c = 1'b1; tick(); abort_c = 1'b0;
    check("cont_abort_valid", 32'(valid_c), 32'd0);
    check("cont_abort_addr", 32'(addr_c), 32'd0);
    check("cont_abort_fd", 32'(frame_done_c), 32'd0);
`ifdef RASTER_FRAME_CNT_EN
    check("frame_count_abort", 32'(frame_count_c), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
